// File: rtl/i2s_tx.sv
// I2S transmitter: 1-deep stereo holding register feeding a 64-bclk frame serializer; optional volume (I2S_TX_VOLUME_EN).
// Latency: a held sample is loaded at the next frame boundary; its left MSB appears 1 bclk later, its right MSB at count 33.
// Backpressure: s_ready is low while the holding register is full; it empties at each frame load.
module i2s_tx #(
    parameter int DATA_W   = 24,
    parameter int BCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    input  logic [3:0]        vol,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              underrun
);

    localparam int DIV_W  = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    // The right slot starts at count 33, so at most 31 of its bits fit before the frame wraps.
    localparam int R_BITS = (DATA_W < 31) ? DATA_W : 31;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DIV_W-1:0]  r_div;
    logic [5:0]        r_cnt;
    logic              r_bclk;
    logic              r_lrclk;
    logic              r_sdata;
    logic              r_underrun;
    logic [63:0]       r_shift;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_hold_r;

    logic              w_tick;
    logic              w_fall;
    logic              w_frame_end;
    logic              w_start;
    logic              w_stop;
    logic              w_load;
    logic              w_accept;
    logic [5:0]        w_cnt_nxt;
    logic [DATA_W-1:0] w_vol_l;
    logic [DATA_W-1:0] w_vol_r;
    logic [DATA_W-1:0] w_load_l;
    logic [DATA_W-1:0] w_load_r;
    logic [63:0]       w_frame;

    // Divider terminal count marks a bclk toggle; a toggle while bclk is high is a falling edge.
    assign w_tick      = (r_state == RUN) && (r_div == DIV_W'(BCLK_DIV - 1));
    assign w_fall      = w_tick && r_bclk;
    assign w_frame_end = w_fall && (r_cnt == 6'd63);
    assign w_start     = (r_state == IDLE) && en && r_hold_full;
    assign w_stop      = w_frame_end && !en;
    assign w_load      = w_start || (w_frame_end && en);
    assign w_accept    = s_valid && !r_hold_full;
    assign w_cnt_nxt   = r_cnt + 6'd1;

`ifdef I2S_TX_VOLUME_EN
    logic [3:0] w_shamt;
    assign w_shamt = 4'hF - vol;
    assign w_vol_l = $signed(r_hold_l) >>> w_shamt;
    assign w_vol_r = $signed(r_hold_r) >>> w_shamt;
`else
    logic w_unused_vol;
    assign w_unused_vol = ^vol;
    assign w_vol_l      = r_hold_l;
    assign w_vol_r      = r_hold_r;
`endif

    // An empty holding register at load time sends silence.
    assign w_load_l = r_hold_full ? w_vol_l : '0;
    assign w_load_r = r_hold_full ? w_vol_r : '0;

    // Lay out one whole frame: bit (63-c) is the sdata value for bit count c.
    always_comb begin
        w_frame = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_frame[62-i] = w_load_l[DATA_W-1-i];
        end
        for (int i = 0; i < R_BITS; i++) begin
            w_frame[30-i] = w_load_r[DATA_W-1-i];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: start once enabled with a sample waiting, stop only on a frame boundary.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = RUN;
            RUN:     if (w_stop)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Holding register: a load empties it, an accept in the same clk refills it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
        end else begin
            if (w_load) begin
                r_hold_full <= 1'b0;
            end
            if (w_accept) begin
                r_hold_full <= 1'b1;
                r_hold_l    <= s_left;
                r_hold_r    <= s_right;
            end
        end
    end

    // Bit clock divider, bit counter and word select; lrclk moves only with bclk falling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_bclk  <= 1'b0;
            r_cnt   <= '0;
            r_lrclk <= 1'b0;
        end else if (r_state == IDLE || w_stop) begin
            r_div   <= '0;
            r_bclk  <= 1'b0;
            r_cnt   <= '0;
            r_lrclk <= 1'b0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
            if (r_bclk) begin
                r_cnt   <= w_cnt_nxt;
                r_lrclk <= w_cnt_nxt[5];
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Frame shifter: load on the boundary, shift one bit out per bclk falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_sdata <= 1'b0;
        end else if (w_load) begin
            r_shift <= {w_frame[62:0], 1'b0};
            r_sdata <= w_frame[63];
        end else if (r_state == IDLE || w_stop) begin
            r_shift <= '0;
            r_sdata <= 1'b0;
        end else if (w_fall) begin
            r_shift <= {r_shift[62:0], 1'b0};
            r_sdata <= r_shift[63];
        end
    end

    // One-clk underrun flag whenever a frame loads with nothing held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_load && !r_hold_full;
        end
    end

    assign s_ready  = !r_hold_full;
    assign bclk     = r_bclk;
    assign lrclk    = r_lrclk;
    assign sdata    = r_sdata;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame-timing reference model driven by elapsed clk time, plus directed and random phases.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_i2s_tx;

    localparam int DW    = 24;
    localparam int DIV   = 4;
    localparam int BITC  = 2 * DIV;
    localparam int FRAME = 64 * BITC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_left = '0;
    logic [DW-1:0] s_right = '0;
    logic [3:0]    vol = 4'hF;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          underrun;

    i2s_tx #(.DATA_W(DW), .BCLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right), .vol(vol), .bclk(bclk),
        .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] vol_apply(input logic [DW-1:0] x, input logic [3:0] v);
`ifdef I2S_TX_VOLUME_EN
        logic signed [DW-1:0] sx;
        sx = x;
        return sx >>> (4'd15 - v);
`else
        logic [3:0] unused_v;
        unused_v = v;
        return x;
`endif
    endfunction

    // Reference model: time since the run started determines every output.
    bit            m_run, m_full, m_under, m_acc, m_load;
    int            m_t;
    int            n_acc = 0;
    logic [DW-1:0] m_hl, m_hr, m_cl, m_cr;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_run = 0; m_full = 0; m_under = 0; m_t = 0;
                m_cl = '0; m_cr = '0;
            end else begin
                m_acc   = s_valid && !m_full;
                m_load  = 0;
                m_under = 0;
                if (!m_run) begin
                    if (en && m_full) begin
                        m_run = 1; m_t = 0; m_load = 1;
                    end
                end else begin
                    m_t++;
                    if (m_t == FRAME) begin
                        m_t = 0;
                        if (en) m_load = 1;
                        else    m_run = 0;
                    end
                end
                if (m_load) begin
                    if (m_full) begin
                        m_cl = vol_apply(m_hl, vol);
                        m_cr = vol_apply(m_hr, vol);
                    end else begin
                        m_cl = '0; m_cr = '0; m_under = 1;
                    end
                    m_full = 0;
                end
                if (m_acc) begin
                    m_full = 1; m_hl = s_left; m_hr = s_right; n_acc++;
                end
            end
        end
    end

    // Per-cycle checker and a receiver that samples sdata on each bclk rise.
    bit          chk_on = 0;
    bit          e_bclk, e_lr, e_sd, prev_ready;
    int          cc;
    int          rx_n = 0;
    int          dut_acc = 0;
    int          last_acc_t = -1;
    logic [63:0] rx_cur = '0;
    logic [63:0] rx_last = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on && !rst) begin
                cc     = m_t / BITC;
                e_bclk = m_run && (((m_t / DIV) % 2) == 1);
                e_lr   = m_run && (cc >= 32);
                e_sd   = 1'b0;
                if (m_run && cc >= 1 && cc <= DW)           e_sd = m_cl[DW-cc];
                else if (m_run && cc >= 33 && cc <= 32 + DW) e_sd = m_cr[DW-(cc-32)];
                chk("bclk", bclk, e_bclk);
                chk("lrclk", lrclk, e_lr);
                chk("sdata", sdata, e_sd);
                chk("s_ready", s_ready, !m_full);
                chk("underrun", underrun, m_under);
                if (s_valid && prev_ready) begin
                    dut_acc++;
                    last_acc_t = m_t;
                end
                if (m_run && (m_t % BITC) == DIV) begin
                    rx_cur[63-cc] = sdata;
                    if (cc == 63) begin
                        rx_last = rx_cur;
                        rx_n++;
                    end
                end
            end
            prev_ready = s_ready;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int a;
        a = n_acc;
        s_valid = 1'b1; s_left = l; s_right = r;
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick(1);
            if (n_acc != a) break;
        end
        s_valid = 1'b0;
        if (n_acc == a) chk("offer_timeout", n_acc, a + 1);
    endtask

    task automatic wait_rx(input int base, input string tag);
        for (int k = 0; k < 3 * FRAME; k++) begin
            if (rx_n > base) break;
            tick(1);
        end
        if (rx_n <= base) chk(tag, rx_n, base + 1);
    endtask

    int base, cnt, hi, ucnt, tog, a0;
    bit pb;

    initial begin
        // Reset state
        tick(3);
        chk("rst_bclk", bclk, 1'b0);
        chk("rst_lrclk", lrclk, 1'b0);
        chk("rst_sdata", sdata, 1'b0);
        chk("rst_ready", s_ready, 1'b1);
        chk("rst_underrun", underrun, 1'b0);
        rst = 1'b0;
        chk_on = 1;

        // Known pattern, bclk period, lrclk duty, then an underrun frame
        vol = 4'hF;
        offer(24'h800001, 24'h7FFFFF);
        en = 1'b1;
        base = rx_n;
        pb = bclk;
        for (int k = 0; k < 4 * BITC; k++) begin
            tick(1);
            if (!pb && bclk) break;
            pb = bclk;
        end
        cnt = 0;
        pb = bclk;
        for (int k = 0; k < 4 * BITC; k++) begin
            tick(1);
            cnt++;
            if (!pb && bclk) break;
            pb = bclk;
        end
        chk("bclk_period", cnt, BITC);
        wait_rx(base, "rx1_timeout");
        chk("left_word", rx_last[62 -: DW], 24'h800001);
        chk("right_word", rx_last[30 -: DW], 24'h7FFFFF);
        chk("left_msb", rx_last[62], 1'b1);
        chk("right_msb", rx_last[30], 1'b0);
        chk("pad_bits", rx_last & ~{1'b0, {DW{1'b1}}, {(31-DW){1'b0}}, 1'b0, {DW{1'b1}}, {(31-DW){1'b0}}}, 64'd0);
        hi = 0; ucnt = 0;
        for (int k = 0; k < FRAME; k++) begin
            tick(1);
            hi += lrclk;
            ucnt += underrun;
        end
        chk("lrclk_duty", hi, FRAME / 2);
        chk("underrun_pulses", ucnt, 1);
        wait_rx(base + 1, "rx2_timeout");
        chk("underrun_frame", rx_last, 64'd0);

        // s_valid held high: one accept per frame, just after the load
        s_valid = 1'b1;
        s_left = DW'($urandom);
        s_right = DW'($urandom);
        wait_rx(rx_n, "rxb_timeout");
        a0 = dut_acc;
        tick(4 * FRAME);
        chk("accepts_4_frames", dut_acc - a0, 4);
        chk("accept_phase", last_acc_t, 1);
        s_valid = 1'b0;

        // Volume applied at load
        en = 1'b0;
        do_reset();
        vol = 4'hE;
        offer(24'h400000, 24'h123456);
        en = 1'b1;
        base = rx_n;
        wait_rx(base, "rxv_timeout");
`ifdef I2S_TX_VOLUME_EN
        chk("vol_left", rx_last[62 -: DW], 24'h200000);
        chk("vol_right", rx_last[30 -: DW], 24'h091A2B);
`else
        chk("vol_left", rx_last[62 -: DW], 24'h400000);
        chk("vol_right", rx_last[30 -: DW], 24'h123456);
`endif

        // Asynchronous reset in the middle of the right slot (count 40, bclk high)
        vol = 4'hF;
        offer(24'hFFFFFF, 24'hFFFFFF);
        for (int k = 0; k < 3 * FRAME; k++) begin
            if (m_run && m_cr == 24'hFFFFFF && m_t == 40 * BITC + DIV + 1) break;
            tick(1);
        end
        chk("pre_rst_bclk", bclk, 1'b1);
        chk("pre_rst_lrclk", lrclk, 1'b1);
        chk("pre_rst_sdata", sdata, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_bclk", bclk, 1'b0);
        chk("async_lrclk", lrclk, 1'b0);
        chk("async_sdata", sdata, 1'b0);
        chk("async_ready", s_ready, 1'b1);
        tick(2);
        rst = 1'b0;
        tog = 0;
        pb = bclk;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick(1);
            if (bclk != pb) tog++;
            pb = bclk;
        end
        chk("no_toggle_after_rst", tog, 0);

        // Random traffic: sparse offers, volume changes, occasional en drops
        for (int k = 0; k < 8000; k++) begin
            s_valid = ($urandom_range(0, 299) == 0);
            s_left  = DW'($urandom);
            s_right = DW'($urandom);
            if ($urandom_range(0, 199) == 0) vol = 4'($urandom);
            if ($urandom_range(0, 2999) == 0) en = ~en;
            tick(1);
        end
        s_valid = 1'b0;
        en = 1'b0;
        tick(2 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning sample width per channel (16..32).
REQ-002 SHALL have parameter BCLK_DIV, default 4, meaning clk cycles per bclk half-period (>=2).
REQ-003 SHALL have port clk, input, 1, meaning the single clock.
REQ-004 SHALL have port rst, input, 1, meaning reset: asynchronous, active-high.
REQ-005 SHALL have port en, input, 1, meaning run request.
REQ-006 SHALL have port s_valid, input, 1, meaning a stereo sample is offered.
REQ-007 SHALL have port s_ready, output, 1, meaning the holding register is empty.
REQ-008 SHALL have port s_left, input, DATA_W, meaning the left sample (two's complement).
REQ-009 SHALL have port s_right, input, DATA_W, meaning the right sample (two's complement).
REQ-010 SHALL have port vol, input, 4, meaning master volume (4'hF = unity).
REQ-011 SHALL have port bclk, output, 1, meaning the I2S bit clock.
REQ-012 SHALL have port lrclk, output, 1, meaning word select (0 = left).
REQ-013 SHALL have port sdata, output, 1, meaning serial data, MSB first.
REQ-014 SHALL have port underrun, output, 1, meaning a one-clk pulse on frame load with no sample.

Function
REQ-015 SHALL accept a sample when s_valid && s_ready at a rising clk edge, latching s_left/s_right into a 1-deep holding register; s_ready = holding empty.
REQ-016 SHALL implement an FSM with states IDLE and RUN.
- IDLE -> RUN when en=1 and holding full.
- RUN -> IDLE at the end of bit 63 of a frame when en=0.
REQ-017 SHALL, in IDLE, drive bclk=0, lrclk=0, sdata=0 and hold the divider and bit counters at 0.
REQ-018 SHALL, in RUN, toggle bclk every BCLK_DIV clk cycles, so that the bclk period is 2*BCLK_DIV clk.
REQ-019 SHALL use a 64-bclk frame: bit counter 0..63, wrapping 63->0.
- lrclk=0 for counts 0..31 and lrclk=1 for counts 32..63.
- lrclk and sdata change only on bclk falling edges.
REQ-020 SHALL follow the I2S one-bit delay: the left MSB appears one bclk after lrclk falls (count 1) and the right MSB at count 33.
- DATA_W bits follow each MSB.
- Remaining slot bits SHALL be 0.
REQ-021 SHALL load the left/right shift registers from holding at the bclk falling edge entering count 0 (and on the IDLE->RUN transition), emptying holding in the same clk.
- A new sample may be accepted in that same clk; the load takes precedence and the accept fills the now-empty register.
REQ-022 SHALL, if holding is empty at a frame load, load zeros for both channels and pulse underrun high for exactly one clk.
REQ-023 SHALL sample vol only at frame load; a vol change mid-frame SHALL affect the next frame only.

Reset
REQ-024 SHALL, on rst=1, immediately (asynchronously) force the following values, including mid-frame:
- state=IDLE
- bclk=0, lrclk=0, sdata=0, underrun=0
- holding empty, so s_ready=1
- all counters and shift registers cleared
REQ-025 SHALL resume from IDLE after rst deasserts; the first frame starts only per REQ-016.

Configuration
REQ-026 SHALL honour macro I2S_TX_VOLUME_EN.
- Defined: each channel SHALL be arithmetically right-shifted by (15 - vol) at load, so vol=4'hF is unity and vol=0 is a >>>15 shift.
- Undefined: vol SHALL be ignored and samples transmitted unmodified.

Verification
REQ-027 SHALL cover: reset, then en=1 with left=24'h800001 and right=24'h7FFFFF (vol=F) -> lrclk falls, then the left MSB=1 at count 1 and the right MSB=0 at count 33, with the bit pattern matching exactly.
REQ-028 SHALL cover: BCLK_DIV=4 -> bclk period is 8 clk and the frame is 512 clk, with lrclk duty 50%.
REQ-029 SHALL cover: no sample offered during the second frame -> underrun pulses once for 1 clk and that frame's sdata is all 0, with s_ready=1 throughout.
REQ-030 SHALL cover: s_valid held 1 continuously -> exactly one sample is accepted per frame, and each acceptance coincides with or follows the frame load.
REQ-031 SHALL cover: with I2S_TX_VOLUME_EN defined, vol=4'hE and left=24'h400000 -> the transmitted left value is 24'h200000; with the macro undefined the transmitted value is 24'h400000.
REQ-032 SHALL cover: rst asserted at count 40 -> on the same edge, bclk, lrclk and sdata go to 0 and s_ready goes to 1, with no further toggling until a re-run.
